// File: rtl/adder_operand_fifo.sv
// Operand buffer feeding eight_bit_adder: DEPTH-entry show-ahead FIFO of {opcode, C, B, A}.
// Define ADDER_OPFIFO_DROP_STATS_EN to add the saturating producer-stall counter drop_count.
module adder_operand_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_A,
   input  logic [7:0]       in_B,
   input  logic [7:0]       in_C,
   input  logic [1:0]       in_opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_A,
   output logic [7:0]       out_B,
   output logic [7:0]       out_C,
   output logic [1:0]       out_opcode,
`ifdef ADDER_OPFIFO_DROP_STATS_EN
   output logic [7:0]       drop_count,
`endif
   output logic [PTR_W:0]   count
);

   logic [25:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [25:0]      head;
   logic             push;
   logic             pop;

   // Handshake flags come only from the registered occupancy, never from pointer equality
   assign in_ready  = (count != (PTR_W + 1)'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_opcode, in_C, in_B, in_A};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      head = mem[rd_ptr];
      if (!out_valid) head = '0;
   end

   assign out_A      = head[7:0];
   assign out_B      = head[15:8];
   assign out_C      = head[23:16];
   assign out_opcode = head[25:24];

`ifdef ADDER_OPFIFO_DROP_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_count <= '0;
      end else if (in_valid && !in_ready && drop_count != 8'hFF) begin
         drop_count <= drop_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_adder_operand_fifo.sv
// Randomized directed bench for adder_operand_fifo against a queue-based reference model.
// Honours ADDER_OPFIFO_DROP_STATS_EN for the optional stall counter.
module tb_adder_operand_fifo;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_A = '0, in_B = '0, in_C = '0;
   logic [1:0] in_opcode = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_A, out_B, out_C;
   logic [1:0] out_opcode;
   logic [2:0] count;
`ifdef ADDER_OPFIFO_DROP_STATS_EN
   logic [7:0] drop_count;
   int         drop_exp = 0;
`endif

   int checks = 0;
   int errors = 0;
   logic [25:0] q[$];

   always #5 clk = ~clk;

   adder_operand_fifo #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_A(in_A), .in_B(in_B), .in_C(in_C), .in_opcode(in_opcode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_opcode(out_opcode),
`ifdef ADDER_OPFIFO_DROP_STATS_EN
      .drop_count(drop_count),
`endif
      .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [25:0] h;
      h = (q.size() > 0) ? q[0] : 26'd0;
      check({tag, ".count"},     32'(count),      32'(q.size()));
      check({tag, ".in_ready"},  32'(in_ready),   32'(q.size() < DEPTH));
      check({tag, ".out_valid"}, 32'(out_valid),  32'(q.size() > 0));
      check({tag, ".out_A"},     32'(out_A),      32'(h[7:0]));
      check({tag, ".out_B"},     32'(out_B),      32'(h[15:8]));
      check({tag, ".out_C"},     32'(out_C),      32'(h[23:16]));
      check({tag, ".out_op"},    32'(out_opcode), 32'(h[25:24]));
   endtask

   // One clock: inputs are already applied; model the edge, then sample 1 time unit after it.
   task automatic cycle(input string tag);
      bit do_push, do_pop;
      logic [25:0] e;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      e = {in_opcode, in_C, in_B, in_A};
`ifdef ADDER_OPFIFO_DROP_STATS_EN
      if (in_valid && q.size() == DEPTH && drop_exp < 255) drop_exp++;
`endif
      @(posedge clk);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [1:0] op, input logic r);
      in_valid = v; in_A = a; in_B = b; in_C = c; in_opcode = op; out_ready = r;
   endtask

   task automatic drive_rand(input logic v, input logic r);
      drive(v, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), r);
   endtask

   initial begin
      // Power-on reset
      rst = 1'b1;
      #12;
      check_all("reset");
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-operation with two entries queued
      drive(1, 8'h21, 8'h22, 8'h23, 2'd1, 0); cycle("pre_rst0");
      drive(1, 8'h31, 8'h32, 8'h33, 2'd2, 0); cycle("pre_rst1");
      drive(0, 0, 0, 0, 0, 0);
      check("pre_rst.count", 32'(count), 32'd2);
      rst = 1'b1;
      #1;
      q.delete();
      check_all("mid_rst");
      #1 rst = 1'b0;
      drive(1, 8'h11, 8'h00, 8'h00, 2'd0, 0); cycle("post_rst_push");
      check("post_rst.out_A", 32'(out_A), 32'h11);
      drive(0, 0, 0, 0, 0, 1); cycle("post_rst_pop");

      // Ordered fill then drain
      drive(1, 8'd1,  8'd2,  8'd3,  2'd0, 0); cycle("fill0");
      drive(1, 8'd4,  8'd5,  8'd6,  2'd1, 0); cycle("fill1");
      drive(1, 8'd7,  8'd8,  8'd9,  2'd2, 0); cycle("fill2");
      drive(1, 8'd10, 8'd11, 8'd12, 2'd3, 0); cycle("fill3");
      check("full.in_ready", 32'(in_ready), 32'd0);
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cycle("drain");
      check("drained.count", 32'(count), 32'd0);

      // Full stall: hold A=AA while full, then pop once
      for (int i = 0; i < DEPTH; i++) begin drive_rand(1, 0); cycle("stall_fill"); end
      drive(1, 8'hAA, 8'h01, 8'h02, 2'd3, 0);
      for (int i = 0; i < 3; i++) cycle("stall_hold");
      out_ready = 1'b1; cycle("stall_pop");
      out_ready = 1'b0; cycle("stall_accept");
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cycle("stall_drain");
      check("stall.last_empty", 32'(out_valid), 32'd0);
`ifdef ADDER_OPFIFO_DROP_STATS_EN
      check("drop_count", 32'(drop_count), 32'(drop_exp));
      check("drop_count_min3", 32'(drop_count >= 8'd3), 32'd1);
`endif

      // Simultaneous push/pop at occupancy 2
      drive_rand(1, 0); cycle("sim_fill0");
      drive_rand(1, 0); cycle("sim_fill1");
      for (int i = 0; i < 10; i++) begin
         drive_rand(1, 1); cycle("sim_pp");
         check("sim_pp.count2", 32'(count), 32'd2);
      end
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle("sim_drain");

      // Wrap-around stream, out_ready toggling; data held until accepted
      begin
         int accepted = 0;
         int guard = 0;
         bit hold = 0;
         while (accepted < 20 && guard < 200) begin
            if (!hold) drive_rand(1, out_ready);
            out_ready = ~out_ready;
            hold = !(q.size() < DEPTH);
            if (!hold) accepted++;
            cycle("wrap");
            guard++;
         end
         check("wrap.accepted", 32'(accepted), 32'd20);
      end
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH + 1; i++) cycle("wrap_drain");

      // Empty output gating
      drive(0, 8'hFF, 8'hFF, 8'hFF, 2'd3, 1);
      for (int i = 0; i < 3; i++) cycle("empty_gate");
      drive(1, 8'h5A, 8'hA5, 8'h3C, 2'd2, 0);
      #1 check("no_bypass.out_valid", 32'(out_valid), 32'd0);
      cycle("empty_then_push");
      drive(0, 0, 0, 0, 0, 1); cycle("final_pop");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder_operand_fifo.md
Name: adder_operand_fifo

Overview:
Upstream operand buffer for the 8-bit add/op unit (eight_bit_adder).
- Accepts operand sets {A, B, C, opcode} from a producer over a valid/ready handshake.
- Stores them in a DEPTH-entry circular FIFO.
- Presents the head entry to the combinational adder with its own valid/ready handshake.
- Decouples producer rate from consumer rate. Its outputs wire straight to the adder's A/B/C/opcode inputs.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of two, at least 2
PTR_W, 2, pointer width; equals log2(DEPTH); override together with DEPTH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  producer has an operand set on in_A/in_B/in_C/in_opcode
in_ready  output  1  FIFO can accept; equals not full
in_A  input  8  operand A
in_B  input  8  operand B
in_C  input  8  operand C
in_opcode  input  2  adder opcode
out_valid  output  1  head entry present; equals not empty
out_ready  input  1  consumer takes the head entry this cycle
out_A  output  8  head operand A to adder
out_B  output  8  head operand B to adder
out_C  output  8  head operand C to adder
out_opcode  output  2  head opcode to adder
count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1, asynchronous, held any duration):
  - wr_ptr=0, rd_ptr=0, count=0.
  - in_ready=1, out_valid=0, out_A/out_B/out_C/out_opcode=0.
  - Storage array is not reset. Contents are discarded.
- Reset asserted mid-operation drops all queued entries immediately, without waiting for a clock edge.
- Entry format: 26 bits {opcode[1:0], C[7:0], B[7:0], A[7:0]}.
- Push: when in_valid && in_ready at a rising edge:
  - the entry is written at wr_ptr;
  - wr_ptr increments modulo DEPTH;
  - count increments.
- Pop: when out_valid && out_ready at a rising edge:
  - rd_ptr increments modulo DEPTH;
  - count decrements.
- Simultaneous push and pop (neither full nor empty): both occur and count is unchanged.
- Full (count==DEPTH):
  - in_ready=0, so no push is possible even if a pop happens in the same cycle. There is no full-bypass.
  - The producer must hold in_valid and its data until in_ready=1.
- Empty (count==0):
  - out_valid=0 and out_* are forced to 0.
  - No same-cycle bypass: a pushed entry first appears on out_* the cycle after the push edge. Push-to-output latency is 1 clock.
- Show-ahead read: out_* reflect the entry at rd_ptr combinationally from registered storage whenever out_valid=1. out_* stay stable until the pop edge.
- Pointer wrap: pointers are PTR_W bits and roll over DEPTH-1 -> 0 naturally. Full/empty are decided from count, never from pointer equality.
- in_ready and out_valid are derived only from registered count. There is no combinational path from in_valid or out_ready to either.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Data integrity: entries leave in exact push order, with all 26 bits unmodified.

Optional Feature:
ADDER_OPFIFO_DROP_STATS_EN
- When defined:
  - Adds output port drop_count, 8 bits.
  - drop_count increments on each rising edge where in_valid=1 and in_ready=0, i.e. a producer stall cycle.
  - It saturates at 255 and resets to 0 on rst.
- When undefined: the port and the counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-cycle with 2 entries queued -> immediately count=0, out_valid=0, in_ready=1, out_A=0. After release, the next push of A=8'h11 appears on out_A one cycle later.
- Ordered fill/drain, out_ready=0: push (A,B,C,op) = (1,2,3,0), (4,5,6,1), (7,8,9,2), (10,11,12,3) -> count=4, in_ready=0. Then set out_ready=1 -> out_* present the four sets in that order on consecutive cycles, then out_valid=0 and count=0.
- Full stall: with the FIFO full, hold in_valid=1 and A=8'hAA for 3 cycles, then pop once -> 8'hAA is accepted on the edge after in_ready rises and is the last entry out. With ADDER_OPFIFO_DROP_STATS_EN, drop_count=3 or more.
- Simultaneous push/pop at count=2 for 10 cycles using random $random operands -> count stays 2, and the output sequence matches a reference queue model.
- Wrap-around: stream 20 random operand sets with out_ready toggling every cycle -> pointers wrap at least 4 times, no loss or duplication. Feed out_* into eight_bit_adder and compare R/C_out against a golden model per popped entry.
- Empty output gating: with the FIFO empty, set out_ready=1 and in_valid=0 -> count remains 0, out_opcode=2'b00, and no pointer movement.
